// File: rtl/serial_adder_sequencer.sv
// Bit-serial adder controller driving one adder_block cell, LSB first.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds the registered signed overflow flag.

module adder_block (
  input  logic b_bit,
  input  logic c_bit,
  input  logic carry_in,
  input  logic carry_in_n,
  output logic sum_bit,
  output logic carry_out,
  output logic carry_out_n
);
  assign sum_bit     = b_bit ^ c_bit ^ carry_in;
  assign carry_out   = (b_bit & c_bit) | (carry_in & (b_bit ^ c_bit));
  // Complement path built from the inverted rails so it can disagree if the cell is faulty
  assign carry_out_n = (~b_bit & ~c_bit) | (carry_in_n & (b_bit ^ c_bit));
endmodule

module serial_adder_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b_reg,
  input  logic [WIDTH-1:0] c_reg,
  input  logic             carry_in_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             zero,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             sign
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] c_sr;
  logic [WIDTH-1:0] psum;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;

  logic             cell_sum;
  logic             cell_cout;
  logic             cell_cout_n;
  logic [WIDTH-1:0] new_sum;

  adder_block u_cell (
    .b_bit      (b_sr[0]),
    .c_bit      (c_sr[0]),
    .carry_in   (carry_q),
    .carry_in_n (~carry_q),
    .sum_bit    (cell_sum),
    .carry_out  (cell_cout),
    .carry_out_n(cell_cout_n)
  );

  // Partial sum including the bit produced this cycle
  assign new_sum = {cell_sum, psum[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam logic [CNT_W-1:0] MSB_IN_BIT = CNT_W'(WIDTH - 2);
  logic msb_carry_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msb_carry_in <= 1'b0;
      overflow     <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt == MSB_IN_BIT) msb_carry_in <= cell_cout;
      if (cnt == LAST_BIT)   overflow     <= msb_carry_in ^ cell_cout;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      b_sr      <= '0;
      c_sr      <= '0;
      psum      <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
      sign      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            b_sr    <= b_reg;
            c_sr    <= c_reg;
            carry_q <= carry_in_init;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          psum    <= new_sum;
          b_sr    <= b_sr >> 1;
          c_sr    <= c_sr >> 1;
          carry_q <= cell_cout;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum       <= new_sum;
            carry_out <= cell_cout;
            zero      <= (new_sum == '0);
            sign      <= new_sum[WIDTH-1];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Cell integrity: complementary carry rails must always disagree
  always_ff @(posedge clk) begin
    if (!reset && state == SHIFT) assert (cell_cout_n == ~cell_cout);
  end
`endif

endmodule
